fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch control stage. It sits between the program counter and the decode stage.
//  - Drives iREN to the icache. The fetch address is imemaddr, taken straight from pc_if.
//  - Computes next_pc and enable_pc for pc_if.
//  - Captures each returned instruction into the IF/ID register.
//  - Handles decode stalls, branch/jump redirects (including a redirect that lands during an
//    icache miss), and halt.
// PARAMETERS
//  PC_STEP   4        byte increment added to imemaddr for sequential fetch
//  BUBBLE    32'h0    instruction word loaded into IF/ID on bubble/flush (sll $0 = nop)
// PORTS
//  CLK          in   1   system clock, all state updates on posedge
//  RST          in   1   asynchronous, active-high reset
//  imemaddr     in   32  current PC (word_t) from pc_if
//  ihit         in   1   icache hit/response valid this cycle
//  imemload     in   32  instruction word, valid when ihit=1
//  stall_id     in   1   hazard unit: hold IF/ID and PC
//  redirect     in   1   branch/jump taken; younger instructions must be flushed
//  redirect_pc  in   32  target address, valid with redirect
//  halt         in   1   halt decoded downstream; stop fetching
//  iREN         out  1   icache read enable
//  next_pc      out  32  value for pc_if.next_pc
//  enable_pc    out  1   value for pc_if.enable_pc
//  instr_id     out  32  IF/ID instruction
//  npc_id       out  32  IF/ID imemaddr+PC_STEP of that instruction
//  valid_id     out  1   IF/ID holds a real instruction (0 = bubble)
// BEHAVIOUR
//  Reset (async, any cycle, mid-miss included):
//   - instr_id=BUBBLE, npc_id=0, valid_id=0, pend_pc=0, state=FETCH.
//   - Outstanding cache response is ignored.
//  Outputs:
//   - iREN = (state!=HALTED).
//   - next_pc, enable_pc are combinational. Everything else is registered.
//   - Arithmetic is 32-bit unsigned. imemaddr+PC_STEP wraps 32'hFFFFFFFC -> 32'h0 with no flag.
//  FSM states {FETCH, REDIR_PEND, HALTED}, evaluated in priority order:
//   halt (any state except HALTED):
//     - Go to HALTED; IF/ID <= bubble; enable_pc=0.
//     - HALTED is left only via RST.
//   FETCH, redirect & ihit:
//     - next_pc=redirect_pc, enable_pc=1, IF/ID <= bubble.
//     - Fetched word is discarded. stall_id is ignored.
//   FETCH, redirect & !ihit:
//     - pend_pc <= redirect_pc; go REDIR_PEND; enable_pc=0; IF/ID <= bubble.
//     - PC stays put so the address of the outstanding request is stable.
//   FETCH, ihit & !stall_id:
//     - IF/ID <= {imemload, imemaddr+PC_STEP, valid=1}.
//     - next_pc=imemaddr+PC_STEP, enable_pc=1.
//   FETCH, ihit & stall_id:
//     - IF/ID holds; enable_pc=0. The same PC refetches next cycle.
//   FETCH, !ihit:
//     - enable_pc=0.
//     - IF/ID <= bubble if !stall_id; holds if stall_id.
//   REDIR_PEND, redirect:
//     - pend_pc <= redirect_pc (newest wins).
//     - If ihit in the same cycle, redirect_pc is used directly.
//   REDIR_PEND, ihit:
//     - Response discarded; next_pc=pend_pc (or redirect_pc per above), enable_pc=1.
//     - IF/ID <= bubble; go FETCH.
//   REDIR_PEND, !ihit:
//     - Hold; IF/ID <= bubble; enable_pc=0.
//  Latency and invariants:
//   - One-cycle latency: ihit in cycle N -> instr_id valid in cycle N+1.
//   - enable_pc is never 1 in the same cycle as a held (stalled) IF/ID.
//   - Outside HALTED, enable_pc=1 only in a cycle with ihit=1.
// STRUCTURE
//  cpu_types_pkg:  word_t (existing).
//  pipeline_types_pkg (shared with decode):
//   - fetch_state_t enum {FETCH, REDIR_PEND, HALTED}
//   - ifid_t struct {instr, npc, valid}
//   - PC_STEP / BUBBLE defaults
//  Sub-module ifid_latch:
//   - Registered ifid_t.
//   - Controls: load, bubble, hold.
//   - Async active-high reset to bubble.
//  fetch_unit holds the FSM, pend_pc, and next_pc/enable_pc logic.
// TESTING
//  1 Sequential: imemaddr=0x100, ihit=1, stall_id=0 -> next_pc=0x104, enable_pc=1;
//    next cycle instr_id=imemload, npc_id=0x104, valid_id=1.
//  2 Stall: ihit=1, stall_id=1 for 3 cycles -> enable_pc=0 and IF/ID unchanged each cycle;
//    release -> load resumes.
//  3 Miss+redirect: ihit=0, redirect=1, redirect_pc=0x200 -> enable_pc=0, state REDIR_PEND;
//    ihit=1 two cycles later -> next_pc=0x200, enable_pc=1, valid_id=0 next cycle.
//  4 Redirect on hit: imemaddr=0x40, ihit=1, redirect=1, redirect_pc=0x80, stall_id=1
//    -> next_pc=0x80, enable_pc=1, valid_id=0.
//  5 Halt: halt=1 -> next cycle iREN=0, enable_pc=0, valid_id=0; remains so with ihit
//    toggling until RST.
//  6 Reset mid-REDIR_PEND and wrap: RST pulse -> all outputs at reset values, state FETCH;
//    imemaddr=0xFFFFFFFC, ihit=1 -> next_pc=0x0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode types: PC word, fetch FSM states, IF/ID bundle.
// Defaults for the sequential PC step and the bubble instruction word.
package fetch_unit_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH      = 2'd0,
        REDIR_PEND = 2'd1,
        HALTED     = 2'd2
    } fetch_state_t;

    typedef struct packed {
        word_t instr;
        word_t npc;
        logic  valid;
    } ifid_t;

    localparam word_t PC_STEP_DEF = 32'd4;
    localparam word_t BUBBLE_DEF  = 32'h0;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: PC, icache, hazard/redirect inputs and IF/ID outputs.
// master = surrounding pipeline, slave = fetch_unit.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    logic  stall_id;
    logic  redirect;
    word_t redirect_pc;
    logic  halt;
    logic  iREN;
    word_t next_pc;
    logic  enable_pc;
    word_t instr_id;
    word_t npc_id;
    logic  valid_id;

    modport master (
        output imemaddr, ihit, imemload, stall_id,
        output redirect, redirect_pc, halt,
        input  iREN, next_pc, enable_pc,
        input  instr_id, npc_id, valid_id
    );

    modport slave (
        input  imemaddr, ihit, imemload, stall_id,
        input  redirect, redirect_pc, halt,
        output iREN, next_pc, enable_pc,
        output instr_id, npc_id, valid_id
    );

endinterface

// File: rtl/fetch_unit_ifid_latch.sv
// IF/ID pipeline register with bubble > hold > load priority.
// Resets asynchronously to a bubble.
module fetch_unit_ifid_latch
    import fetch_unit_pkg::*;
#(
    parameter word_t BUBBLE = BUBBLE_DEF
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  bubble,
    input  logic  hold,
    input  ifid_t d,
    output ifid_t q
);

    ifid_t nop;
    assign nop = '{instr: BUBBLE, npc: '0, valid: 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= nop;
        end else if (bubble) begin
            q <= nop;
        end else if (load && !hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch control: PC advance, redirect (incl. during a miss),
// decode stalls and halt, feeding the IF/ID register.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter word_t PC_STEP = PC_STEP_DEF,
    parameter word_t BUBBLE  = BUBBLE_DEF
) (
    input logic         CLK,
    input logic         RST,
    fetch_unit_if.slave bus
);

    fetch_state_t state_q, state_d;
    word_t        pend_q, pend_d;
    word_t        seq_pc, target, next_pc;
    logic         enable_pc, load, bubble;
    ifid_t        ifid_d, ifid_q;

    assign seq_pc = bus.imemaddr + PC_STEP;
    // newest redirect wins even when it arrives with the pending response
    assign target = bus.redirect ? bus.redirect_pc : pend_q;

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        next_pc   = seq_pc;
        enable_pc = 1'b0;
        load      = 1'b0;
        bubble    = 1'b0;
        if (state_q != HALTED && bus.halt) begin
            state_d = HALTED;
            bubble  = 1'b1;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (bus.redirect && bus.ihit) begin
                        next_pc   = bus.redirect_pc;
                        enable_pc = 1'b1;
                        bubble    = 1'b1;
                    end else if (bus.redirect) begin
                        // keep PC so the outstanding miss address stays stable
                        pend_d  = bus.redirect_pc;
                        state_d = REDIR_PEND;
                        bubble  = 1'b1;
                    end else if (bus.ihit) begin
                        load      = !bus.stall_id;
                        enable_pc = !bus.stall_id;
                    end else begin
                        bubble = !bus.stall_id;
                    end
                end
                REDIR_PEND: begin
                    bubble = 1'b1;
                    if (bus.redirect) begin
                        pend_d = bus.redirect_pc;
                    end
                    if (bus.ihit) begin
                        next_pc   = target;
                        enable_pc = 1'b1;
                        state_d   = FETCH;
                    end
                end
                HALTED: begin
                    state_d = HALTED;
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= FETCH;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    assign ifid_d = '{instr: bus.imemload, npc: seq_pc, valid: 1'b1};

    fetch_unit_ifid_latch #(
        .BUBBLE(BUBBLE)
    ) u_ifid (
        .clk   (CLK),
        .rst   (RST),
        .load  (load),
        .bubble(bubble),
        .hold  (bus.stall_id),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign bus.iREN      = (state_q != HALTED);
    assign bus.next_pc   = next_pc;
    assign bus.enable_pc = enable_pc;
    assign bus.instr_id  = ifid_q.instr;
    assign bus.npc_id    = ifid_q.npc;
    assign bus.valid_id  = ifid_q.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall, redirects,
// halt, async reset and PC wrap.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    fetch_unit_if bus ();

    fetch_unit dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input word_t got, input word_t exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input word_t a, input logic h, input word_t ld,
                         input logic st, input logic rd, input word_t rpc,
                         input logic hl);
        bus.imemaddr    = a;
        bus.ihit        = h;
        bus.imemload    = ld;
        bus.stall_id    = st;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.halt        = hl;
        #1;
    endtask

    task automatic chk_ifid(input string tag, input word_t ins,
                            input word_t npc, input logic v);
        chk({tag, ".instr"}, bus.instr_id, ins);
        chk({tag, ".npc"}, bus.npc_id, npc);
        chk({tag, ".valid"}, {31'b0, bus.valid_id}, {31'b0, v});
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b1;
        drive(32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        chk_ifid("rst", 32'h0, 32'h0, 1'b0);
        chk("rst.iren", {31'b0, bus.iREN}, 32'd1);
        rst = 1'b0;

        // 1 sequential fetch
        drive(32'h100, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("seq.next_pc", bus.next_pc, 32'h104);
        chk("seq.en", {31'b0, bus.enable_pc}, 32'd1);
        tick();
        chk_ifid("seq", 32'hDEAD_BEEF, 32'h104, 1'b1);

        // 2 stall for 3 cycles, then release
        for (int i = 0; i < 3; i++) begin
            drive(32'h104, 1'b1, 32'h1111_1111, 1'b1, 1'b0, 32'h0, 1'b0);
            chk("stall.en", {31'b0, bus.enable_pc}, 32'd0);
            tick();
            chk_ifid("stall", 32'hDEAD_BEEF, 32'h104, 1'b1);
        end
        drive(32'h104, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("rel.next_pc", bus.next_pc, 32'h108);
        chk("rel.en", {31'b0, bus.enable_pc}, 32'd1);
        tick();
        chk_ifid("rel", 32'h1111_1111, 32'h108, 1'b1);

        // miss without stall inserts a bubble
        drive(32'h108, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("miss.en", {31'b0, bus.enable_pc}, 32'd0);
        tick();
        chk("miss.valid", {31'b0, bus.valid_id}, 32'd0);

        // 3 redirect during a miss, response two cycles later
        drive(32'h108, 1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 1'b0);
        chk("mr.en", {31'b0, bus.enable_pc}, 32'd0);
        tick();
        drive(32'h108, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("mr.wait.en", {31'b0, bus.enable_pc}, 32'd0);
        tick();
        drive(32'h108, 1'b1, 32'h5555_5555, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("mr.next_pc", bus.next_pc, 32'h200);
        chk("mr.en1", {31'b0, bus.enable_pc}, 32'd1);
        tick();
        chk("mr.valid", {31'b0, bus.valid_id}, 32'd0);
        drive(32'h200, 1'b1, 32'h2222_2222, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("mr.back.next_pc", bus.next_pc, 32'h204);
        tick();
        chk_ifid("mr.back", 32'h2222_2222, 32'h204, 1'b1);

        // newest pending redirect wins
        drive(32'h204, 1'b0, 32'h0, 1'b0, 1'b1, 32'h300, 1'b0);
        tick();
        drive(32'h204, 1'b0, 32'h0, 1'b0, 1'b1, 32'h400, 1'b0);
        tick();
        drive(32'h204, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("newest.next_pc", bus.next_pc, 32'h400);
        tick();
        // redirect coinciding with the pending hit uses redirect_pc
        drive(32'h400, 1'b0, 32'h0, 1'b0, 1'b1, 32'h500, 1'b0);
        tick();
        drive(32'h400, 1'b1, 32'h0, 1'b0, 1'b1, 32'h600, 1'b0);
        chk("samecyc.next_pc", bus.next_pc, 32'h600);
        tick();

        // 4 redirect on hit ignores stall
        drive(32'h40, 1'b1, 32'h7777_7777, 1'b1, 1'b1, 32'h80, 1'b0);
        chk("rh.next_pc", bus.next_pc, 32'h80);
        chk("rh.en", {31'b0, bus.enable_pc}, 32'd1);
        tick();
        chk("rh.valid", {31'b0, bus.valid_id}, 32'd0);

        // 5 halt, sticky until reset
        drive(32'h80, 1'b1, 32'h8888_8888, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("halt.en", {31'b0, bus.enable_pc}, 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(32'h80, i[0], 32'h9999_9999, 1'b0, 1'b0, 32'h0, 1'b0);
            chk("halted.iren", {31'b0, bus.iREN}, 32'd0);
            chk("halted.en", {31'b0, bus.enable_pc}, 32'd0);
            tick();
            chk("halted.valid", {31'b0, bus.valid_id}, 32'd0);
        end

        // 6 reset leaves HALTED, then async reset in REDIR_PEND
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
        chk("unhalt.iren", {31'b0, bus.iREN}, 32'd1);
        drive(32'h10, 1'b1, 32'h3333_3333, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        chk_ifid("pre", 32'h3333_3333, 32'h14, 1'b1);
        drive(32'h14, 1'b0, 32'h0, 1'b0, 1'b1, 32'h900, 1'b0);
        tick();
        drive(32'h14, 1'b1, 32'hAAAA_AAAA, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        chk_ifid("arst", 32'h0, 32'h0, 1'b0);
        chk("arst.iren", {31'b0, bus.iREN}, 32'd1);
        tick();
        rst = 1'b0;
        drive(32'hFFFF_FFFC, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("wrap.next_pc", bus.next_pc, 32'h0);
        chk("wrap.en", {31'b0, bus.enable_pc}, 32'd1);
        tick();
        chk_ifid("wrap", 32'hCAFE_F00D, 32'h0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
